// File: rtl/memarb_pkg.sv
// Shared types and sizing helpers for the shared-memory arbiter.
package memarb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

    // Wait counter holds W-1 at most, so clog2 of the larger wait fits it.
    function automatic int cnt_width(input int ram_wait, input int fl_wait);
        int m;
        m = (ram_wait > fl_wait) ? ram_wait : fl_wait;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/memarb_if.sv
// Channel handshake and external memory pin bundle for memarb.
interface memarb_if #(
    parameter int NCH = 2,
    parameter int AW  = 16,
    parameter int MAW = 23
);
    logic [NCH-1:0]            ch_req;
    logic [NCH-1:0]            ch_we;
    logic [NCH-1:0]            ch_fl;
    logic [NCH*AW-1:0]         ch_addr;
    logic [NCH*(MAW-AW)-1:0]   ch_page;
    logic [NCH*16-1:0]         ch_wdata;
    logic [NCH*16-1:0]         ch_rdata;
    logic [NCH-1:0]            ch_rdy;
    logic [MAW-1:0]            mem_addr;
    logic [15:0]               mem_dout;
    logic                      mem_doe;
    logic [15:0]               mem_din;
    logic                      mem_oe_n;
    logic                      mem_we_n;
    logic                      mem_ramcs_n;
    logic                      mem_flcs_n;

    modport slave (
        input  ch_req, ch_we, ch_fl, ch_addr, ch_page, ch_wdata, mem_din,
        output ch_rdata, ch_rdy, mem_addr, mem_dout, mem_doe,
               mem_oe_n, mem_we_n, mem_ramcs_n, mem_flcs_n
    );

    modport master (
        output ch_req, ch_we, ch_fl, ch_addr, ch_page, ch_wdata, mem_din,
        input  ch_rdata, ch_rdy, mem_addr, mem_dout, mem_doe,
               mem_oe_n, mem_we_n, mem_ramcs_n, mem_flcs_n
    );
endinterface

// File: rtl/memarb_rr.sv
// Request arbiter: round-robin from the last winner, or fixed lowest-index priority.
module memarb_rr
    import memarb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter bit FIXED_PRIO = 1'b0,
    localparam int IW        = idx_width(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant_oh,
    output logic [IW-1:0]  grant_idx,
    output logic           grant_any
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand_idx;
    int            start;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand_idx  = '0;
        start     = FIXED_PRIO ? 0 : int'(ptr_q) + 1;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand_idx = IW'((start + k) % NCH);
            if (req[cand_idx]) begin
                grant_idx = cand_idx;
                grant_any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_oh
        assign grant_oh[gi] = grant_any && (grant_idx == IW'(gi));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_any) ptr_d = grant_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= IW'(NCH - 1);
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/memarb.sv
// Multi-master arbiter and timed access sequencer for the shared 16-bit RAM/flash bus.
module memarb
    import memarb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int AW         = 16,
    parameter int MAW        = 23,
    parameter int RAM_WAIT   = 2,
    parameter int FL_WAIT    = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    memarb_if.slave   bus
);
    localparam int CW = cnt_width(RAM_WAIT, FL_WAIT);
    localparam int PW = MAW - AW;
    localparam int IW = idx_width(NCH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, fl_q;
    logic [MAW-1:0]  addr_q;
    logic [15:0]     wdata_q;
    logic [NCH-1:0]  sel_q;
    logic [15:0]     rdata_q [NCH];

    logic [NCH-1:0]  grant_oh;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic            grant_take;
    logic [MAW-1:0]  g_addr;
    logic [15:0]     g_wdata;
    logic            capture;

    logic            ramcs_n, flcs_n, oe_n, we_n, doe;
    logic [NCH-1:0]  rdy;

    assign grant_take = (state_q == IDLE) && grant_any;

    memarb_rr #(.NCH(NCH), .FIXED_PRIO(FIXED_PRIO)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.ch_req),
        .advance   (grant_take),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_oh[i]) begin
                g_addr  = {bus.ch_page[i*PW +: PW], bus.ch_addr[i*AW +: AW]};
                g_wdata = bus.ch_wdata[i*16 +: 16];
            end
        end
    end

    // Channel fields are captured once at grant; later changes never reach the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            fl_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_take) begin
                we_q    <= bus.ch_we[grant_idx];
                fl_q    <= bus.ch_fl[grant_idx];
                addr_q  <= g_addr;
                wdata_q <= g_wdata;
                sel_q   <= grant_oh;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (grant_any) state_d = SETUP;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = fl_q ? CW'(FL_WAIT - 1) : CW'(RAM_WAIT - 1);
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramcs_n = 1'b1;
        flcs_n  = 1'b1;
        oe_n    = 1'b1;
        we_n    = 1'b1;
        doe     = 1'b0;
        rdy     = '0;
        case (state_q)
            SETUP: begin
                ramcs_n = fl_q;
                flcs_n  = !fl_q;
                doe     = we_q;
            end
            ACCESS: begin
                ramcs_n = fl_q;
                flcs_n  = !fl_q;
                oe_n    = we_q;
                we_n    = !we_q;
                doe     = we_q;
            end
            HOLD:    rdy = sel_q;
            default: ;
        endcase
    end

    // Read data is sampled on the edge that ends the last ACCESS cycle.
    assign capture = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        always_ff @(posedge clk) begin
            if (reset)                     rdata_q[gi] <= '0;
            else if (capture && sel_q[gi]) rdata_q[gi] <= bus.mem_din;
        end
    end

    always_comb begin
        bus.ch_rdata = '0;
        for (int i = 0; i < NCH; i++) bus.ch_rdata[i*16 +: 16] = rdata_q[i];
    end

    assign bus.ch_rdy      = rdy;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_dout    = wdata_q;
    assign bus.mem_doe     = doe;
    assign bus.mem_oe_n    = oe_n;
    assign bus.mem_we_n    = we_n;
    assign bus.mem_ramcs_n = ramcs_n;
    assign bus.mem_flcs_n  = flcs_n;
endmodule
